// File: rtl/async_fifo_gray_if.sv
// ============================================================================
// Module   : async_fifo_gray_if
// Brief    : Handshake bundle for the dual-clock gray-pointer FIFO. The
//            w_ovf/r_udf error flags exist only with ASYNC_FIFO_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface async_fifo_gray_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              w_push;
  logic [DATA_W-1:0] w_data;
  logic              w_full;
  logic              w_afull;
  logic [ADDR_W:0]   w_level;
  logic              r_pop;
  logic [DATA_W-1:0] r_data;
  logic              r_empty;
  logic              r_aempty;
  logic [ADDR_W:0]   r_level;
`ifdef ASYNC_FIFO_ERR_EN
  logic              w_ovf;
  logic              r_udf;

  modport master (output w_push, w_data, r_pop,
                  input  w_full, w_afull, w_level, r_data, r_empty, r_aempty, r_level,
                         w_ovf, r_udf);
  modport slave  (input  w_push, w_data, r_pop,
                  output w_full, w_afull, w_level, r_data, r_empty, r_aempty, r_level,
                         w_ovf, r_udf);
`else
  modport master (output w_push, w_data, r_pop,
                  input  w_full, w_afull, w_level, r_data, r_empty, r_aempty, r_level);
  modport slave  (input  w_push, w_data, r_pop,
                  output w_full, w_afull, w_level, r_data, r_empty, r_aempty, r_level);
`endif
endinterface

`default_nettype wire

// File: rtl/async_fifo_gray.sv
// ============================================================================
// Module   : async_fifo_gray
// Brief    : Dual-clock DATA_W x 2**ADDR_W FIFO, gray pointers crossing
//            through SYNC_STAGES flops. Optional sticky error flags under
//            ASYNC_FIFO_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module async_fifo_gray #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = 6,
  parameter int AEMPTY_TH   = 1
) (
  input wire               w_clk,
  input wire               w_rst,
  input wire               r_clk,
  input wire               r_rst,
  async_fifo_gray_if.slave bus
);

  localparam int              C_DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_FULL_MASK = (ADDR_W+1)'(3) << (ADDR_W-1);
  localparam logic [ADDR_W:0] C_AFULL_TH  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] C_AEMPTY_TH = (ADDR_W+1)'(AEMPTY_TH);

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W-1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_W-1:0] mem_q [C_DEPTH];

  // ---------------------------------------------------------------- write side
  logic [ADDR_W:0] wbin_q, wbin_d, wgray_q, rgray_q;
  logic [ADDR_W:0] rgray_sync_q [SYNC_STAGES];
  logic [ADDR_W:0] rbin_sync, w_level;
  logic            w_full, w_accept;

  assign w_accept = bus.w_push & ~w_full;
  assign wbin_d   = wbin_q + (ADDR_W+1)'(w_accept);

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) rgray_sync_q[i] <= '0;
    end else begin
      wbin_q          <= wbin_d;
      wgray_q         <= wbin_d ^ (wbin_d >> 1);
      rgray_sync_q[0] <= rgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) rgray_sync_q[i] <= rgray_sync_q[i-1];
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_accept) mem_q[wbin_q[ADDR_W-1:0]] <= bus.w_data;
  end

  // Full when the write pointer is exactly one lap ahead: top two gray bits inverted.
  assign w_full        = (wgray_q == (rgray_sync_q[SYNC_STAGES-1] ^ C_FULL_MASK));
  assign rbin_sync     = gray2bin(rgray_sync_q[SYNC_STAGES-1]);
  assign w_level       = wbin_q - rbin_sync;
  assign bus.w_full    = w_full;
  assign bus.w_level   = w_level;
  assign bus.w_afull   = (w_level >= C_AFULL_TH);

  // ----------------------------------------------------------------- read side
  logic [ADDR_W:0]   rbin_q, rbin_d;
  logic [ADDR_W:0]   wgray_sync_q [SYNC_STAGES];
  logic [ADDR_W:0]   wbin_sync, r_level;
  logic [DATA_W-1:0] r_data_q;
  logic              r_empty, r_accept;

  assign r_accept = bus.r_pop & ~r_empty;
  assign rbin_d   = rbin_q + (ADDR_W+1)'(r_accept);

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      r_data_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) wgray_sync_q[i] <= '0;
    end else begin
      rbin_q          <= rbin_d;
      rgray_q         <= rbin_d ^ (rbin_d >> 1);
      wgray_sync_q[0] <= wgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) wgray_sync_q[i] <= wgray_sync_q[i-1];
      if (r_accept) r_data_q <= mem_q[rbin_q[ADDR_W-1:0]];
    end
  end

  assign r_empty       = (rgray_q == wgray_sync_q[SYNC_STAGES-1]);
  assign wbin_sync     = gray2bin(wgray_sync_q[SYNC_STAGES-1]);
  assign r_level       = wbin_sync - rbin_q;
  assign bus.r_empty   = r_empty;
  assign bus.r_level   = r_level;
  assign bus.r_aempty  = (r_level <= C_AEMPTY_TH);
  assign bus.r_data    = r_data_q;

`ifdef ASYNC_FIFO_ERR_EN
  logic w_ovf_q, r_udf_q;

  always_ff @(posedge w_clk) begin
    if (w_rst)                      w_ovf_q <= 1'b0;
    else if (bus.w_push & w_full)   w_ovf_q <= 1'b1;
  end

  always_ff @(posedge r_clk) begin
    if (r_rst)                      r_udf_q <= 1'b0;
    else if (bus.r_pop & r_empty)   r_udf_q <= 1'b1;
  end

  assign bus.w_ovf = w_ovf_q;
  assign bus.r_udf = r_udf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_async_fifo_gray.sv
// ============================================================================
// Module   : tb_async_fifo_gray
// Brief    : Directed + randomized bench for async_fifo_gray against a
//            queue-based FIFO model. ASYNC_FIFO_ERR_EN enables flag checks.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_async_fifo_gray;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int SS    = 2;
  localparam int DEPTH = 1 << AW;

  logic w_clk = 1'b0, r_clk = 1'b0, w_rst = 1'b1, r_rst = 1'b1;
  real  w_half = 5.0, r_half = 13.5;

  always #(w_half) w_clk = ~w_clk;
  always #(r_half) r_clk = ~r_clk;

  async_fifo_gray_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  async_fifo_gray #(
    .DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(SS), .AFULL_TH(6), .AEMPTY_TH(1)
  ) dut (
    .w_clk(w_clk), .w_rst(w_rst), .r_clk(r_clk), .r_rst(r_rst), .bus(bus)
  );

  int n_vec = 0, n_err = 0;
  logic [DW-1:0] model_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    @(posedge w_clk); #1;
    check("wlvl_ge_model", 32'(bus.w_level >= AW'(model_q.size())), 32'd1);
    bus.w_push = 1'b1;
    bus.w_data = d;
    if (!bus.w_full) model_q.push_back(d);
    @(posedge w_clk); #1;
    bus.w_push = 1'b0;
  endtask

  task automatic pop_word();
    int n = 0;
    logic [DW-1:0] exp;
    @(posedge r_clk); #1;
    while (bus.r_empty && n < 40) begin
      @(posedge r_clk); #1;
      n++;
    end
    check("pop_wait_nonempty", 32'(bus.r_empty), 32'd0);
    if (bus.r_empty) return;
    exp = (model_q.size() != 0) ? model_q.pop_front() : 'x;
    bus.r_pop = 1'b1;
    @(posedge r_clk); #1;
    bus.r_pop = 1'b0;
    check("rdata", 32'(bus.r_data), 32'(exp));
  endtask

  task automatic settle();
    repeat (12) @(posedge r_clk);
    repeat (4) @(posedge w_clk);
    #1;
  endtask

  task automatic reset_both();
    w_rst = 1'b1;
    r_rst = 1'b1;
    bus.w_push = 1'b0;
    bus.r_pop  = 1'b0;
    model_q.delete();
    repeat (4) @(posedge r_clk);
    repeat (2) @(posedge w_clk);
    #1;
    w_rst = 1'b0;
    r_rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_w_full"},   32'(bus.w_full),   32'd0);
    check({tag, "_w_afull"},  32'(bus.w_afull),  32'd0);
    check({tag, "_w_level"},  32'(bus.w_level),  32'd0);
    check({tag, "_r_empty"},  32'(bus.r_empty),  32'd1);
    check({tag, "_r_aempty"}, 32'(bus.r_aempty), 32'd1);
    check({tag, "_r_level"},  32'(bus.r_level),  32'd0);
  endtask

  // Randomized streaming phase: producer and consumer run concurrently.
  task automatic stream(input int words);
    int sent = 0, got = 0;
    fork
      begin : writer
        int guard = 0;
        while (sent < words && guard < 40000) begin
          @(posedge w_clk); #1;
          guard++;
          check("s_wlvl_ge_model", 32'(bus.w_level >= AW'(model_q.size())), 32'd1);
          check("s_wlvl_le_depth", 32'(bus.w_level <= (AW+1)'(DEPTH)), 32'd1);
          if ($urandom_range(3) != 0) begin
            bus.w_push = 1'b1;
            bus.w_data = DW'($urandom);
            if (!bus.w_full) begin
              model_q.push_back(bus.w_data);
              sent++;
            end
          end else begin
            bus.w_push = 1'b0;
          end
        end
        @(posedge w_clk); #1;
        bus.w_push = 1'b0;
        check("s_all_sent", 32'(sent), 32'(words));
      end
      begin : reader
        int guard = 0;
        logic pend = 1'b0;
        logic [DW-1:0] exp = '0;
        while ((got < words || pend) && guard < 120000) begin
          @(posedge r_clk); #1;
          guard++;
          if (pend) begin
            check("s_rdata", 32'(bus.r_data), 32'(exp));
            pend = 1'b0;
          end
          check("s_rlvl_le_model", 32'(bus.r_level <= (AW+1)'(model_q.size())), 32'd1);
          bus.r_pop = 1'b0;
          if (got < words && $urandom_range(3) != 0) begin
            bus.r_pop = 1'b1;
            if (!bus.r_empty) begin
              exp  = (model_q.size() != 0) ? model_q.pop_front() : 'x;
              pend = 1'b1;
              got++;
            end
          end
        end
        bus.r_pop = 1'b0;
        check("s_all_received", 32'(got), 32'(words));
      end
    join
  endtask

  initial begin
    int n;
    logic [DW-1:0] exp;
    bus.w_push = 1'b0;
    bus.w_data = '0;
    bus.r_pop  = 1'b0;

    reset_both();
    @(posedge w_clk); #1;
    check_idle("reset");
    check("reset_r_data", 32'(bus.r_data), 32'd0);
`ifdef ASYNC_FIFO_ERR_EN
    check("reset_w_ovf", 32'(bus.w_ovf), 32'd0);
    check("reset_r_udf", 32'(bus.r_udf), 32'd0);
`endif

    // Fill to capacity, try one overflow push, then drain in order.
    for (int i = 0; i < DEPTH; i++) push_word(DW'(8'h10 + i));
    check("fill_w_full",  32'(bus.w_full),  32'd1);
    check("fill_w_level", 32'(bus.w_level), 32'(DEPTH));
    check("fill_w_afull", 32'(bus.w_afull), 32'd1);
    push_word(8'hFF);
    check("ovf_w_full_hold", 32'(bus.w_full), 32'd1);
    check("ovf_w_level",     32'(bus.w_level), 32'(DEPTH));
`ifdef ASYNC_FIFO_ERR_EN
    check("ovf_w_ovf", 32'(bus.w_ovf), 32'd1);
`endif
    settle();
    check("fill_r_level",  32'(bus.r_level),  32'(DEPTH));
    check("fill_r_empty",  32'(bus.r_empty),  32'd0);
    check("fill_r_aempty", 32'(bus.r_aempty), 32'd0);
    for (int i = 0; i < DEPTH; i++) pop_word();
    settle();
    check_idle("drained");
`ifdef ASYNC_FIFO_ERR_EN
    check("drained_w_ovf_sticky", 32'(bus.w_ovf), 32'd1);
`endif

    // Pop while empty must leave r_data untouched.
    @(posedge r_clk); #1;
    bus.r_pop = 1'b1;
    @(posedge r_clk); #1;
    bus.r_pop = 1'b0;
    check("udf_r_data_hold", 32'(bus.r_data), 32'h17);
    check("udf_r_empty",     32'(bus.r_empty), 32'd1);
`ifdef ASYNC_FIFO_ERR_EN
    check("udf_r_udf", 32'(bus.r_udf), 32'd1);
`endif

    // Single word: empty-flag latency and low-level flags.
    @(posedge w_clk); #1;
    bus.w_push = 1'b1;
    bus.w_data = 8'h5A;
    model_q.push_back(8'h5A);
    @(posedge w_clk);
    fork begin #1; bus.w_push = 1'b0; end join_none
    n = 0;
    while (bus.r_empty && n < 10) begin
      @(posedge r_clk);
      n++;
      #1;
    end
    check("empty_latency_ok", 32'(n <= SS + 1), 32'd1);
    check("one_r_level",  32'(bus.r_level),  32'd1);
    check("one_r_aempty", 32'(bus.r_aempty), 32'd1);
    pop_word();
    settle();

    // Almost-full at 6 and its release latency after one pop.
    for (int i = 0; i < 6; i++) push_word(DW'(8'h60 + i));
    check("af_w_afull", 32'(bus.w_afull), 32'd1);
    check("af_w_level", 32'(bus.w_level), 32'd6);
    check("af_w_full",  32'(bus.w_full),  32'd0);
    settle();
    @(posedge r_clk); #1;
    exp = model_q.pop_front();
    bus.r_pop = 1'b1;
    @(posedge r_clk);
    fork begin #1; bus.r_pop = 1'b0; end join_none
    n = 0;
    while (bus.w_afull && n < 10) begin
      @(posedge w_clk);
      n++;
      #1;
    end
    check("afull_release_ok", 32'(n <= SS + 1), 32'd1);
    check("af_pop_rdata",     32'(bus.r_data),  32'(exp));
    check("af_w_level_after", 32'(bus.w_level), 32'd5);

    // Joint reset with 5 words held, then a round trip.
    reset_both();
    @(posedge w_clk); #1;
    check_idle("midreset");
    check("midreset_r_data", 32'(bus.r_data), 32'd0);
`ifdef ASYNC_FIFO_ERR_EN
    check("midreset_w_ovf", 32'(bus.w_ovf), 32'd0);
    check("midreset_r_udf", 32'(bus.r_udf), 32'd0);
`endif
    push_word(8'hA5);
    pop_word();
    settle();

    // Randomized streaming with r_clk three times faster than w_clk.
    w_half = 6.0;
    r_half = 2.0;
    settle();
    stream(1000);
    settle();
    check_idle("stream_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
